led_share_arb: RTL and testbench

- Arbitrates the single RGB LED among three LED pattern sources, e.g. blink-speed engine, status indicator and alarm flasher.
- Each source raises a level request. The block grants one source at a time in round-robin order.
- It enforces a minimum and a maximum hold time, and inserts a forced-off gap between owners.
- It drives LED_RGB from the granted source and sits between the pattern generators and the board LED pins.

---
 rtl/led_share_arb.sv | 125 ++++++++++++
 tb/tb_led_share_arb.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_share_arb.sv
// Round-robin owner arbitration for the shared RGB LED among three pattern sources.
// Each owner holds the LED between a minimum and maximum time, and a forced-off gap separates owners.
module led_share_arb #(
  parameter int unsigned      CNT_W    = 27,
  parameter logic [CNT_W-1:0] MIN_HOLD = 27'd62_500_000,
  parameter logic [CNT_W-1:0] MAX_HOLD = 27'd125_000_000,
  parameter logic [CNT_W-1:0] GAP_CYC  = 27'd12_500_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] REQ,
  input  logic [2:0] LED_IN0,
  input  logic [2:0] LED_IN1,
  input  logic [2:0] LED_IN2,
  output logic [2:0] GNT,
  output logic [1:0] OWNER,
  output logic [2:0] LED_RGB
);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_GAP} state_t;

  localparam logic [CNT_W-1:0] MIN_M1 = MIN_HOLD - 1'b1;
  localparam logic [CNT_W-1:0] MAX_M1 = MAX_HOLD - 1'b1;
  localparam logic [CNT_W-1:0] GAP_M1 = GAP_CYC - 1'b1;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       gnt_q;
  logic [2:0]       led_q;
  logic [1:0]       owner_q;

  logic [1:0]       win_d;
  logic [2:0]       own_oh;
  logic [2:0]       others;
  logic             own_req;
  logic             release_d;
  logic [CNT_W-1:0] cnt_inc_d;
  logic [2:0]       own_led;

  // Search starts just after the last owner, so it only wins again when alone.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] a, b, c;
    case (last)
      2'd0:    begin a = 2'd1; b = 2'd2; c = 2'd0; end
      2'd1:    begin a = 2'd2; b = 2'd0; c = 2'd1; end
      default: begin a = 2'd0; b = 2'd1; c = 2'd2; end
    endcase
    if (req[a])      return a;
    else if (req[b]) return b;
    return c;
  endfunction

  always_comb begin
    win_d     = rr_pick(REQ, owner_q);
    own_oh    = 3'b001 << owner_q;
    others    = REQ & ~own_oh;
    own_req   = |(REQ & own_oh);
    release_d = (!own_req && (cnt_q >= MIN_M1)) ||
                ((|others) && (cnt_q >= MAX_M1));
    cnt_inc_d = (cnt_q >= MAX_M1) ? MAX_M1 : cnt_q + 1'b1;
    case (owner_q)
      2'd0:    own_led = LED_IN0;
      2'd1:    own_led = LED_IN1;
      default: own_led = LED_IN2;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gnt_q   <= 3'b000;
      led_q   <= 3'b000;
      owner_q <= 2'd2;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|REQ) begin
            state_q <= S_OWN;
            gnt_q   <= 3'b001 << win_d;
            owner_q <= win_d;
            cnt_q   <= '0;
          end
        end
        S_OWN: begin
          if (release_d) begin
            state_q <= S_GAP;
            gnt_q   <= 3'b000;
            led_q   <= 3'b000;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_inc_d;
            led_q   <= own_led;
          end
        end
        S_GAP: begin
          // Gap end hands straight to the next owner without an idle cycle.
          if (cnt_q >= GAP_M1) begin
            cnt_q <= '0;
            if (|REQ) begin
              state_q <= S_OWN;
              gnt_q   <= 3'b001 << win_d;
              owner_q <= win_d;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= 3'b000;
          led_q   <= 3'b000;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign GNT     = gnt_q;
  assign OWNER   = owner_q;
  assign LED_RGB = led_q;

endmodule

// File: tb/tb_led_share_arb.sv
// Bench for led_share_arb: directed scenarios plus random traffic against a grant-age reference model.
module tb_led_share_arb;

  localparam int MINH = 4, MAXH = 16, GAPC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic [2:0] led0 = 3'b000, led1 = 3'b000, led2 = 3'b000;
  logic [2:0] GNT, LED_RGB;
  logic [1:0] OWNER;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  led_share_arb #(.CNT_W(8), .MIN_HOLD(8'd4), .MAX_HOLD(8'd16), .GAP_CYC(8'd2)) dut (
    .CLK(clk), .RST(rst), .REQ(req),
    .LED_IN0(led0), .LED_IN1(led1), .LED_IN2(led2),
    .GNT(GNT), .OWNER(OWNER), .LED_RGB(LED_RGB)
  );

  // Reference: an owner is "held" for m_age granted cycles; after release m_gap off-cycles remain.
  bit         m_held;
  int         m_age, m_gap, m_last;
  logic [2:0] m_gnt, m_led;
  logic [1:0] m_owner;

  function automatic int rr(logic [2:0] r, int last);
    for (int k = 1; k <= 3; k++)
      if (r[(last + k) % 3]) return (last + k) % 3;
    return -1;
  endfunction

  function automatic logic [2:0] led_of(int s);
    return (s == 0) ? led0 : (s == 1) ? led1 : led2;
  endfunction

  task automatic grant();
    m_last = rr(req, m_last);
    m_held = 1;
    m_age  = 1;
    m_gnt  = 3'b001 << m_last;
  endtask

  task automatic model_step();
    if (rst) begin
      m_held = 0; m_gap = 0; m_age = 0; m_last = 2;
      m_gnt = 3'b000; m_led = 3'b000;
    end else if (m_held) begin
      if ((!req[m_last] && m_age >= MINH) ||
          (((req & ~(3'b001 << m_last)) != 3'b000) && m_age >= MAXH)) begin
        m_held = 0; m_gap = GAPC; m_gnt = 3'b000; m_led = 3'b000;
      end else begin
        m_age++;
        m_led = led_of(m_last);
      end
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0 && req != 3'b000) grant();
    end else if (req != 3'b000) begin
      grant();
    end
    m_owner = 2'(m_last);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 3'b000;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 3'b111;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if ({GNT, LED_RGB, OWNER} !== {3'b000, 3'b000, 2'd2}) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d gnt=%b led=%b owner=%0d want 000/000/2", i, GNT, LED_RGB, OWNER);
      end
    end
    rst = 1'b0;
    step();
    n_vec++;
    if (GNT !== 3'b001) begin
      n_err++;
      $display("FAIL reset_first_gnt gnt=%b want 001", GNT);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 3'b001; led0 = 3'b100; led1 = 3'b011; led2 = 3'b111;
    step();
    n_vec++;
    if (GNT !== 3'b001) begin n_err++; $display("FAIL single_gnt gnt=%b want 001", GNT); end
    step();
    n_vec++;
    if (LED_RGB !== 3'b100) begin n_err++; $display("FAIL single_led led=%b want 100", LED_RGB); end
    for (int i = 0; i < 12; i++) begin
      if (i == 4) req = 3'b000;
      step();
      n_vec++;
      if ({GNT, LED_RGB, OWNER} !== {m_gnt, m_led, m_owner}) begin
        n_err++;
        $display("FAIL single_seq cyc=%0d gnt=%b led=%b owner=%0d want %b/%b/%0d", i, GNT, LED_RGB, OWNER, m_gnt, m_led, m_owner);
      end
    end
  endtask

  task automatic test_short_pulse();
    int hi;
    hi = 0;
    do_reset();
    step();
    led1 = 3'b010;
    req = 3'b010;
    for (int i = 0; i < 10; i++) begin
      step();
      req = 3'b000;
      if (GNT == 3'b010) hi++;
      n_vec++;
      if ({GNT, LED_RGB, OWNER} !== {m_gnt, m_led, m_owner}) begin
        n_err++;
        $display("FAIL pulse_seq cyc=%0d gnt=%b led=%b owner=%0d want %b/%b/%0d", i, GNT, LED_RGB, OWNER, m_gnt, m_led, m_owner);
      end
    end
    n_vec++;
    if (hi !== MINH || OWNER !== 2'd1) begin
      n_err++;
      $display("FAIL pulse_len hi=%0d owner=%0d want %0d/1", hi, OWNER, MINH);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] hist[$];
    logic [2:0] rv[$];
    int         rl[$];
    logic [2:0] ev[7];
    int         el[7];
    ev = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    el = '{16, 2, 16, 2, 16, 2, 16};
    do_reset();
    led0 = 3'b001; led1 = 3'b010; led2 = 3'b100;
    req = 3'b111;
    for (int i = 0; i < 74; i++) begin
      step();
      hist.push_back(GNT);
      n_vec++;
      if ({GNT, LED_RGB, OWNER} !== {m_gnt, m_led, m_owner}) begin
        n_err++;
        $display("FAIL rr_seq cyc=%0d gnt=%b led=%b owner=%0d want %b/%b/%0d", i, GNT, LED_RGB, OWNER, m_gnt, m_led, m_owner);
      end
    end
    foreach (hist[i]) begin
      if (rv.size() == 0 || rv[rv.size()-1] !== hist[i]) begin
        rv.push_back(hist[i]); rl.push_back(1);
      end else begin
        rl[rl.size()-1] += 1;
      end
    end
    n_vec++;
    if (rv.size() < 8) begin
      n_err++;
      $display("FAIL rr_runs count=%0d want >=8", rv.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_vec++;
        if (rv[i] !== ev[i] || rl[i] != el[i]) begin
          n_err++;
          $display("FAIL rr_run%0d gnt=%b len=%0d want %b/%0d", i, rv[i], rl[i], ev[i], el[i]);
        end
      end
    end
  endtask

  task automatic test_rewin();
    do_reset();
    led2 = 3'b110;
    req = 3'b100;
    for (int i = 0; i < 36; i++) begin
      if (i == 5) req = 3'b101;
      if (i == 8) req = 3'b100;
      step();
      n_vec++;
      if (GNT !== 3'b100 || GNT !== m_gnt || LED_RGB !== m_led) begin
        n_err++;
        $display("FAIL rewin_keep cyc=%0d gnt=%b led=%b want 100/%b", i, GNT, LED_RGB, m_led);
      end
    end
    req = 3'b101;
    for (int i = 0; i < 4; i++) begin
      step();
      n_vec++;
      if ({GNT, LED_RGB, OWNER} !== {m_gnt, m_led, m_owner}) begin
        n_err++;
        $display("FAIL rewin_preempt cyc=%0d gnt=%b led=%b owner=%0d want %b/%b/%0d", i, GNT, LED_RGB, OWNER, m_gnt, m_led, m_owner);
      end
    end
    n_vec++;
    if (GNT !== 3'b001) begin n_err++; $display("FAIL rewin_next gnt=%b want 001", GNT); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    led1 = 3'b111;
    req = 3'b010;
    step(); step(); step();
    n_vec++;
    if (GNT !== 3'b010 || LED_RGB !== 3'b111) begin
      n_err++;
      $display("FAIL rstmid_pre gnt=%b led=%b want 010/111", GNT, LED_RGB);
    end
    rst = 1'b1;
    step();
    n_vec++;
    if ({GNT, LED_RGB, OWNER} !== {3'b000, 3'b000, 2'd2}) begin
      n_err++;
      $display("FAIL rstmid gnt=%b led=%b owner=%0d want 000/000/2", GNT, LED_RGB, OWNER);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    int hold;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 20);
        req  = 3'($urandom);
        rst  = ($urandom_range(0, 99) == 0);
      end
      hold--;
      led0 = 3'($urandom); led1 = 3'($urandom); led2 = 3'($urandom);
      step();
      n_vec++;
      if ({GNT, LED_RGB, OWNER} !== {m_gnt, m_led, m_owner} || !$onehot0(GNT)) begin
        n_err++;
        $display("FAIL random cyc=%0d gnt=%b led=%b owner=%0d want %b/%b/%0d", i, GNT, LED_RGB, OWNER, m_gnt, m_led, m_owner);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_short_pulse();
    test_round_robin();
    test_rewin();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
